// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: start/pause/abort controlled 4-bit up-counter, one-shot or auto-reload.
// Latency: q, done and state update on the rising clk edge after the inputs are sampled;
//          busy is a decode of the registered state. No backpressure: inputs act every cycle.
// Ports:
//   clk       single clock, rising edge
//   reset     synchronous active-high reset
//   start     begin a run (honoured only in IDLE or DONE)
//   pause     level; freezes counting while high in RUN/PAUSE
//   abort     terminate the run and return to IDLE (no done pulse)
//   periodic  1 = reload to 0 at terminal count, 0 = stop in DONE; latched with start
//   limit     terminal count value; latched with start
//   q         registered count value
//   busy      high in RUN or PAUSE
//   done      one-cycle pulse following each terminal-count edge
//   state     FSM code: IDLE=00 RUN=01 PAUSE=10 DONE=11
module count_seq_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       pause,
   input  logic       abort,
   input  logic       periodic,
   input  logic [3:0] limit,
   output logic [3:0] q,
   output logic       busy,
   output logic       done,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      DONE  = 2'b11
   } state_t;

   state_t     cur;
   logic [3:0] limit_r;
   logic       periodic_r;

   always_ff @(posedge clk) begin
      if (reset) begin
         cur        <= IDLE;
         q          <= 4'd0;
         done       <= 1'b0;
         limit_r    <= 4'd0;
         periodic_r <= 1'b0;
      end else begin
         // done is a pulse: cleared every cycle unless a terminal count fires below
         done <= 1'b0;
         case (cur)
            IDLE: begin
               q <= 4'd0;
               if (start && !abort) begin
                  cur        <= RUN;
                  limit_r    <= limit;
                  periodic_r <= periodic;
               end
            end
            RUN: begin
               if (abort) begin
                  cur <= IDLE;
                  q   <= 4'd0;
               end else if (pause) begin
                  // pause outranks a terminal count landing in the same cycle
                  cur <= PAUSE;
               end else if (q != limit_r) begin
                  q <= q + 4'd1;
               end else begin
                  done <= 1'b1;
                  if (periodic_r) begin
                     q <= 4'd0;
                  end else begin
                     cur <= DONE;
                  end
               end
            end
            PAUSE: begin
               if (abort) begin
                  cur <= IDLE;
                  q   <= 4'd0;
               end else if (!pause) begin
                  // q is held on the resume edge; counting restarts on the next one
                  cur <= RUN;
               end
            end
            DONE: begin
               if (abort) begin
                  cur <= IDLE;
                  q   <= 4'd0;
               end else if (start) begin
                  cur        <= RUN;
                  q          <= 4'd0;
                  limit_r    <= limit;
                  periodic_r <= periodic;
               end
            end
            default: begin
               cur <= IDLE;
               q   <= 4'd0;
            end
         endcase
      end
   end

   assign busy  = (cur == RUN) || (cur == PAUSE);
   assign state = cur;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb_count_seq_ctrl: directed vectors for count_seq_ctrl with hand-written expected outputs.
// Each vector's expected post-edge outputs are queued by the driver; a monitor pops and
// compares one entry after every rising edge.
module tb_count_seq_ctrl;

   localparam logic [1:0] S_I = 2'b00;
   localparam logic [1:0] S_R = 2'b01;
   localparam logic [1:0] S_P = 2'b10;
   localparam logic [1:0] S_D = 2'b11;

   logic       clk;
   logic       reset;
   logic       start;
   logic       pause;
   logic       abort;
   logic       periodic;
   logic [3:0] limit;
   logic [3:0] q;
   logic       busy;
   logic       done;
   logic [1:0] state;

   typedef struct {
      int         id;
      logic [1:0] st;
      logic [3:0] q;
      logic       done;
      logic       busy;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec;
   int   n_bad;
   int   vid;

   count_seq_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .pause    (pause),
      .abort    (abort),
      .periodic (periodic),
      .limit    (limit),
      .q        (q),
      .busy     (busy),
      .done     (done),
      .state    (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs at the falling edge and queue the outputs expected after the
   // following rising edge.
   task automatic v(input logic r, input logic s, input logic p, input logic a,
                    input logic per, input logic [3:0] lim,
                    input logic [1:0] est, input logic [3:0] eq, input logic ed, input logic eb);
      exp_t e;
      @(negedge clk);
      reset    = r;
      start    = s;
      pause    = p;
      abort    = a;
      periodic = per;
      limit    = lim;
      e.id   = vid;
      e.st   = est;
      e.q    = eq;
      e.done = ed;
      e.busy = eb;
      exp_q.push_back(e);
      vid++;
   endtask

   // Monitor: every rising edge (+1) with a pending expectation is one compared vector.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (state !== e.st || q !== e.q || done !== e.done || busy !== e.busy) begin
               n_bad++;
               $display("FAIL vec%0d: got state=%b q=%0d done=%b busy=%b, want state=%b q=%0d done=%b busy=%b",
                        e.id, state, q, done, busy, e.st, e.q, e.done, e.busy);
            end
         end
      end
   end

   initial begin
      n_vec = 0;
      n_bad = 0;
      vid   = 0;
      reset = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0; periodic = 1'b0; limit = 4'd0;

      // reset state
      v(1,0,0,0,0,4'd0,  S_I,4'd0,0,0);
      v(0,0,0,0,0,4'd0,  S_I,4'd0,0,0);

      // one-shot limit 5; limit input changes after start must not matter
      v(0,1,0,0,0,4'd5,  S_R,4'd0,0,1);
      v(0,0,0,0,1,4'd0,  S_R,4'd1,0,1);
      v(0,0,0,0,0,4'd0,  S_R,4'd2,0,1);
      v(0,0,0,0,0,4'd0,  S_R,4'd3,0,1);
      v(0,0,0,0,0,4'd0,  S_R,4'd4,0,1);
      v(0,0,0,0,0,4'd0,  S_R,4'd5,0,1);
      v(0,0,0,0,0,4'd0,  S_D,4'd5,1,0);
      v(0,0,0,0,0,4'd0,  S_D,4'd5,0,0);
      v(0,0,0,0,0,4'd0,  S_D,4'd5,0,0);

      // periodic limit 3 started from DONE
      v(0,1,0,0,1,4'd3,  S_R,4'd0,0,1);
      v(0,0,0,0,0,4'd0,  S_R,4'd1,0,1);
      v(0,0,0,0,0,4'd0,  S_R,4'd2,0,1);
      v(0,0,0,0,0,4'd0,  S_R,4'd3,0,1);
      v(0,0,0,0,0,4'd0,  S_R,4'd0,1,1);
      v(0,0,0,0,0,4'd0,  S_R,4'd1,0,1);
      v(0,0,0,0,0,4'd0,  S_R,4'd2,0,1);
      v(0,0,0,0,0,4'd0,  S_R,4'd3,0,1);
      v(0,0,0,0,0,4'd0,  S_R,4'd0,1,1);
      v(0,0,0,0,0,4'd0,  S_R,4'd1,0,1);
      // start ignored while running
      v(0,1,0,0,0,4'd9,  S_R,4'd2,0,1);
      v(0,0,0,1,0,4'd0,  S_I,4'd0,0,0);

      // one-shot limit 9 with a 3-cycle pause at q=4
      v(0,1,0,0,0,4'd9,  S_R,4'd0,0,1);
      v(0,0,0,0,0,4'd0,  S_R,4'd1,0,1);
      v(0,0,0,0,0,4'd0,  S_R,4'd2,0,1);
      v(0,0,0,0,0,4'd0,  S_R,4'd3,0,1);
      v(0,0,0,0,0,4'd0,  S_R,4'd4,0,1);
      v(0,0,1,0,0,4'd0,  S_P,4'd4,0,1);
      v(0,1,1,0,0,4'd0,  S_P,4'd4,0,1);
      v(0,0,1,0,0,4'd0,  S_P,4'd4,0,1);
      v(0,0,0,0,0,4'd0,  S_R,4'd4,0,1);
      v(0,0,0,0,0,4'd0,  S_R,4'd5,0,1);
      v(0,0,0,0,0,4'd0,  S_R,4'd6,0,1);
      v(0,0,0,0,0,4'd0,  S_R,4'd7,0,1);
      v(0,0,0,0,0,4'd0,  S_R,4'd8,0,1);
      v(0,0,0,0,0,4'd0,  S_R,4'd9,0,1);
      v(0,0,0,0,0,4'd0,  S_D,4'd9,1,0);
      v(0,0,0,0,0,4'd0,  S_D,4'd9,0,0);

      // pause on the terminal-count cycle wins: no done until resumed
      v(0,1,0,0,0,4'd2,  S_R,4'd0,0,1);
      v(0,0,0,0,0,4'd0,  S_R,4'd1,0,1);
      v(0,0,0,0,0,4'd0,  S_R,4'd2,0,1);
      v(0,0,1,0,0,4'd0,  S_P,4'd2,0,1);
      v(0,0,0,0,0,4'd0,  S_R,4'd2,0,1);
      v(0,0,0,0,0,4'd0,  S_D,4'd2,1,0);

      // limit 7, abort at q=3 while pause is high
      v(0,1,0,0,0,4'd7,  S_R,4'd0,0,1);
      v(0,0,0,0,0,4'd0,  S_R,4'd1,0,1);
      v(0,0,0,0,0,4'd0,  S_R,4'd2,0,1);
      v(0,0,0,0,0,4'd0,  S_R,4'd3,0,1);
      v(0,0,1,1,0,4'd0,  S_I,4'd0,0,0);
      v(0,0,0,0,0,4'd0,  S_I,4'd0,0,0);
      // start with abort in IDLE is refused
      v(0,1,0,1,0,4'd7,  S_I,4'd0,0,0);
      v(0,1,0,0,0,4'd7,  S_R,4'd0,0,1);
      v(0,0,0,0,0,4'd0,  S_R,4'd1,0,1);
      // abort from PAUSE
      v(0,0,1,0,0,4'd0,  S_P,4'd1,0,1);
      v(0,0,1,1,0,4'd0,  S_I,4'd0,0,0);

      // limit 0 one-shot; limit input changed to 12 during the run
      v(0,1,0,0,0,4'd0,  S_R,4'd0,0,1);
      v(0,0,0,0,0,4'd12, S_D,4'd0,1,0);
      v(0,0,0,0,0,4'd12, S_D,4'd0,0,0);

      // limit 0 periodic: done every cycle, q stays 0; then abort from DONE-less run
      v(0,1,0,0,1,4'd0,  S_R,4'd0,0,1);
      v(0,0,0,0,0,4'd0,  S_R,4'd0,1,1);
      v(0,0,0,0,0,4'd0,  S_R,4'd0,1,1);
      v(0,0,0,1,0,4'd0,  S_I,4'd0,0,0);

      // limit 15 periodic: full 0..15 then reload
      v(0,1,0,0,1,4'd15, S_R,4'd0,0,1);
      for (int i = 1; i <= 15; i++) begin
         v(0,0,0,0,0,4'd0, S_R,4'(i),0,1);
      end
      v(0,0,0,0,0,4'd0,  S_R,4'd0,1,1);
      v(0,0,0,1,0,4'd0,  S_I,4'd0,0,0);

      // reset with start at q=6
      v(0,1,0,0,0,4'd9,  S_R,4'd0,0,1);
      for (int i = 1; i <= 6; i++) begin
         v(0,0,0,0,0,4'd0, S_R,4'(i),0,1);
      end
      v(1,1,0,0,0,4'd9,  S_I,4'd0,0,0);
      v(0,0,0,0,0,4'd0,  S_I,4'd0,0,0);

      // reset landing on a terminal-count edge suppresses done
      v(0,1,0,0,0,4'd1,  S_R,4'd0,0,1);
      v(0,0,0,0,0,4'd0,  S_R,4'd1,0,1);
      v(1,0,0,0,0,4'd0,  S_I,4'd0,0,0);
      v(0,0,0,0,0,4'd0,  S_I,4'd0,0,0);

      // reset in DONE
      v(0,1,0,0,0,4'd0,  S_R,4'd0,0,1);
      v(0,0,0,0,0,4'd0,  S_D,4'd0,1,0);
      v(1,1,0,0,0,4'd3,  S_I,4'd0,0,0);

      // let the monitor drain the queue, bounded
      for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
         @(posedge clk);
         #2;
      end
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/count_seq_ctrl.md
COUNT_SEQ_CTRL -- requirements
Module: count_seq_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port start, input, 1, begin a count run (sampled in IDLE or DONE only).
REQ-004 SHALL have port pause, input, 1, level; freeze counting while high in RUN/PAUSE.
REQ-005 SHALL have port abort, input, 1, terminate run, return to IDLE.
REQ-006 SHALL have port periodic, input, 1, 1 = auto-reload at terminal count, 0 = one-shot; sampled with start.
REQ-007 SHALL have port limit, input, 4, terminal count value; sampled with start.
REQ-008 SHALL have port q, output, 4, registered count value.
REQ-009 SHALL have port busy, output, 1, high in RUN or PAUSE.
REQ-010 SHALL have port done, output, 1, registered single-cycle terminal-count pulse.
REQ-011 SHALL have port state, output, 2, current FSM state code.

Function
REQ-012 SHALL implement FSM states IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, DONE=2'b11.
REQ-013 SHALL latch limit into limit_r and periodic into periodic_r on the edge where start is accepted; later changes to limit/periodic have no effect on the run.
REQ-014 IDLE: start=1 and abort=0 -> RUN, q<=0; otherwise remain IDLE, q held at 0.
REQ-015 RUN, priority abort > pause > count: abort -> IDLE, q<=0; else pause -> PAUSE, q held; else count step.
REQ-016 Count step: q!=limit_r -> q<=q+1 (4-bit, no overflow possible since q<=limit_r); q==limit_r -> done<=1 and periodic_r=1: q<=0, stay RUN; periodic_r=0: q held, go DONE.
REQ-017 limit_r=0: terminal count on first RUN cycle; periodic mode yields done every cycle with q=0.
REQ-018 limit_r=15: q runs 0..15; terminal detected at 15, no wrap by increment.
REQ-019 PAUSE: abort -> IDLE, q<=0; else pause=0 -> RUN (counting resumes next edge); else stay, q held.
REQ-020 DONE: abort -> IDLE, q<=0; else start=1 -> RUN, q<=0, new limit/periodic latched; else stay, q held at limit_r.
REQ-021 start SHALL be ignored in RUN and PAUSE.
REQ-022 done SHALL be high exactly one cycle per terminal count, never in response to abort; done=0 in every cycle not immediately following a terminal-count edge.
REQ-023 busy SHALL be a decode of the registered state (no combinational path from inputs).
REQ-024 Terminal count with pause=1 in the same cycle: pause wins, no done, q held.

Reset
REQ-025 reset=1 at a clock edge SHALL force state=IDLE, q=0, done=0, busy=0, limit_r=0, periodic_r=0, overriding all other inputs including start.
REQ-026 reset asserted mid-run (RUN/PAUSE/DONE) SHALL abandon the run with no done pulse.

Verification
REQ-027 Reset, then start=1 one cycle, limit=5, periodic=0 -> q 0,1,2,3,4,5 on successive edges; state DONE and done=1 for one cycle after q=5; q holds 5, busy=0.
REQ-028 limit=3, periodic=1 -> q sequence 0,1,2,3,0,1,2,3..., done pulses once each time q returns to 0, busy stays 1.
REQ-029 limit=9 one-shot, pause=1 for 3 cycles at q=4 -> state PAUSE, q=4 held 3 cycles, resumes 5..9, single done.
REQ-030 limit=7, abort at q=3 while pause=1 -> state IDLE, q=0, no done; subsequent start restarts from 0.
REQ-031 limit=0 periodic=0 -> DONE after first RUN cycle, done=1 once, q=0; limit change to 12 during RUN has no effect.
REQ-032 reset asserted with start=1 at q=6 -> next cycle IDLE, q=0, done=0, busy=0.
